sipo_deser: RTL
===============

// Module: sipo_deser
// PURPOSE
//  Serial-in/parallel-out deserialiser feeding the N-bit PIPO register stage.
//  Shifts in framed serial bits; after N valid bits, presents a stable N-bit word plus a 1-cycle strobe.
//  QVALID drives the PIPO EN input directly; Q drives its D input.
//  Aborted or misaligned frames are flagged on a sticky error bit.
// PARAMETERS
//  N          8   word width in bits; N >= 2
//  MSB_FIRST  1   1: first serial bit lands in Q[N-1]; 0: first bit lands in Q[0]
// PORTS
//  CLK     in   1  system clock, all state updates on rising edge
//  res     in   1  synchronous, active-high reset
//  SIN     in   1  serial data bit
//  SVALID  in   1  SIN qualifier; bit consumed only on a rising edge where SVALID=1
//  FRAME   in   1  with SVALID=1, marks SIN as bit 0 of a new word
//  CLR     in   1  clears ERR
//  Q       out  N  last complete word; stable between QVALID strobes
//  QVALID  out  1  1-cycle strobe: Q updated with a new word this cycle
//  BUSY    out  1  1 while a word is partially received (state SHIFT)
//  ERR     out  1  sticky: a frame was aborted by an early FRAME
// BEHAVIOUR
//  - Reset (res=1 at rising edge): Q=0, QVALID=0, BUSY=0, ERR=0, state=IDLE, cnt=0, shift reg=0.
//    Reset overrides every other input; a partial word is discarded.
//  - FSM states: IDLE, SHIFT. BUSY = (state==SHIFT), registered.
//  - IDLE: SVALID&FRAME -> capture SIN as bit 0, cnt=1, go SHIFT.
//    SVALID&!FRAME -> bit discarded, no state change. SVALID=0 -> hold.
//  - SHIFT, SVALID=0: hold all state; gaps of any length are allowed.
//  - SHIFT, SVALID&!FRAME: capture SIN, cnt++.
//    On the edge capturing bit N-1: Q <= assembled word, QVALID=1 for the next cycle, cnt=0, go IDLE.
//  - SHIFT, SVALID&FRAME: abort the partial word (Q unchanged, no QVALID), ERR<=1.
//    Capture SIN as bit 0 of the new word, cnt=1, stay SHIFT.
//  - Shift direction:
//    MSB_FIRST=1: sh <= {sh[N-2:0], SIN}.
//    MSB_FIRST=0: sh <= {SIN, sh[N-1:1]}.
//    The word is loaded into Q from the shift reg with the final bit included in the same edge.
//  - Latency: word visible on Q, with QVALID=1, in the cycle after the edge sampling bit N-1.
//  - Back-to-back: FRAME on the cycle right after completion starts the next word.
//    Max throughput is one word per N cycles.
//  - QVALID is never high for two consecutive cycles. Q changes only in cycles where QVALID=1, and on reset.
//  - ERR: set has priority over CLR in the same cycle; CLR alone clears ERR next cycle.
//  - cnt width $clog2(N); cnt never exceeds N-1.
// STRUCTURE
//  - Package sipo_pkg: typedef enum logic {IDLE, SHIFT} sipo_state_t.
//  - Sub-module bit_cntN #(N): mod-N counter with sync clear, load-to-1 and increment enable.
//    It outputs cnt and last = (cnt==N-1).
//  - Top: FSM, shift register, Q/QVALID/ERR registers.
// TESTING (N=8, MSB_FIRST=1; drive inputs on falling edge, check after rising)
//  1. res=1 for 2 cycles with SVALID=1, FRAME=1 -> Q=8'h00, QVALID=0, BUSY=0, ERR=0.
//  2. Send 8'hA5 with SVALID=1 continuously and FRAME on bit 0 -> BUSY=1 for 7 cycles.
//     QVALID=1 for exactly 1 cycle with Q=8'hA5, then BUSY=0.
//  3. Send 8'h3C with SVALID=0 for 3 cycles between bits 3 and 4 -> single QVALID, Q=8'h3C.
//  4. Send 4 bits (1111), then FRAME + full 8'h81 -> ERR=1, one QVALID, Q=8'h81.
//     Pulse CLR -> ERR=0.
//  5. SVALID=1, FRAME=0 for 10 cycles from IDLE -> no QVALID, BUSY=0, Q keeps previous value.
//  6. After 5 bits of a word, pulse res -> BUSY=0, Q=8'h00; then send 8'h5A -> Q=8'h5A.
//     Also run 8'h5A and 8'hC3 back-to-back -> two strobes 8 cycles apart.

Source files
------------

// File: rtl/sipo_deser_pkg.sv
// Shared types for the serial-in/parallel-out deserialiser.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sipo_pkg;

  // IDLE: waiting for a framed bit 0; SHIFT: word partially received
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input / parallel word output bundle for sipo_deser.
// Latency: n/a (wiring only).
// Backpressure: none; the serial side is qualified by SVALID, the word side is a 1-cycle strobe.
//   SIN/SVALID/FRAME : serial bit, qualifier, word-start marker
//   CLR              : clears the sticky ERR flag
//   Q/QVALID         : completed word and its 1-cycle strobe
//   BUSY/ERR         : word in progress / sticky aborted-frame flag
interface sipo_deser_if #(
  parameter int N = 8
);
  logic         SIN;
  logic         SVALID;
  logic         FRAME;
  logic         CLR;
  logic [N-1:0] Q;
  logic         QVALID;
  logic         BUSY;
  logic         ERR;

  modport master (
    output SIN, SVALID, FRAME, CLR,
    input  Q, QVALID, BUSY, ERR
  );

  modport slave (
    input  SIN, SVALID, FRAME, CLR,
    output Q, QVALID, BUSY, ERR
  );
endinterface

// File: rtl/sipo_deser_bit_cnt.sv
// Mod-N bit counter: sync clear, load-to-1, increment; flags the last bit position.
// Latency: cnt updates one cycle after clr/load1/inc; last is combinational from cnt.
// Backpressure: none; holds when no control input is active.
//   CLK, res : clock, synchronous active-high reset
//   clr      : force cnt to 0 (highest priority after reset)
//   load1    : force cnt to 1 (bit 0 of a new word was just taken)
//   inc      : advance cnt, wrapping N-1 -> 0
//   cnt      : current bit index
//   last     : cnt == N-1
module bit_cntN #(
  parameter int N = 8
) (
  input  logic                 CLK,
  input  logic                 res,
  input  logic                 clr,
  input  logic                 load1,
  input  logic                 inc,
  output logic [$clog2(N)-1:0] cnt,
  output logic                 last
);
  localparam int CW = $clog2(N);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = CW'(1);
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CW'(N - 1));
endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser: frames N serial bits into a word for the PIPO stage.
// Latency: word on Q with a 1-cycle QVALID in the cycle after the edge sampling bit N-1.
// Backpressure: none; gaps on SVALID stall the shift, an early FRAME aborts and sets sticky ERR.
//   CLK, res : clock, synchronous active-high reset
//   bus      : slave side of sipo_deser_if (SIN/SVALID/FRAME/CLR in, Q/QVALID/BUSY/ERR out)
//   MSB_FIRST: 1 puts the first serial bit in Q[N-1], 0 puts it in Q[0]
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        CLK,
  input  logic        res,
  sipo_deser_if.slave bus
);
  localparam int CW = $clog2(N);

  sipo_state_t  state_d, state_q;
  logic [N-1:0] sh_d, sh_q;
  logic [N-1:0] q_d, q_q;
  logic         qvld_d, qvld_q;
  logic         err_d, err_q;

  logic [N-1:0] sh_next;
  logic         cnt_clr, cnt_load1, cnt_inc;
  logic [CW-1:0] bit_idx;
  logic         bit_last;

  bit_cntN #(.N(N)) u_cnt (
    .CLK   (CLK),
    .res   (res),
    .clr   (cnt_clr),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .cnt   (bit_idx),
    .last  (bit_last)
  );

  // Shift reg with the incoming bit already merged, so the final bit can go
  // straight into Q on the completing edge.
  assign sh_next = MSB_FIRST ? {sh_q[N-2:0], bus.SIN} : {bus.SIN, sh_q[N-1:1]};

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    q_d       = q_q;
    qvld_d    = 1'b0;
    err_d     = bus.CLR ? 1'b0 : err_q;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;

    if (bus.SVALID) begin
      unique case (state_q)
        IDLE: begin
          // Unframed bits in IDLE are dropped.
          if (bus.FRAME) begin
            sh_d      = sh_next;
            cnt_load1 = 1'b1;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          sh_d = sh_next;
          if (bus.FRAME) begin
            // Early FRAME: drop the partial word, restart on this bit.
            // Setting ERR wins over a simultaneous CLR.
            err_d     = 1'b1;
            cnt_load1 = 1'b1;
          end else if (bit_last) begin
            q_d     = sh_next;
            qvld_d  = 1'b1;
            cnt_clr = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (res) begin
      state_q <= IDLE;
      sh_q    <= '0;
      q_q     <= '0;
      qvld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      qvld_q  <= qvld_d;
      err_q   <= err_d;
      // The bit index wraps at the last position and must never run past it.
      assert (bit_idx <= CW'(N - 1));
    end
  end

  assign bus.Q      = q_q;
  assign bus.QVALID = qvld_q;
  assign bus.BUSY   = (state_q == SHIFT);
  assign bus.ERR    = err_q;
endmodule
